// File: rtl/dmem_ctrl_pkg.sv
// Shared widths, timeout default and FSM state encoding for the data-memory controller.
package dmem_ctrl_pkg;

    localparam int unsigned AddrW          = 32;
    localparam int unsigned DataW          = 32;
    localparam int unsigned WeW            = 4;
    localparam int unsigned TimerW         = 8;
    localparam int unsigned TimeoutDefault = 255;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_ctrl_if.sv
// Req/ack data SRAM bus; the controller is the master, the SRAM side is the slave.
interface dmem_ctrl_if;
    import dmem_ctrl_pkg::*;

    logic             req;
    logic [WeW-1:0]   we;
    logic [AddrW-1:0] addr;
    logic [DataW-1:0] wdata;
    logic             ack;
    logic [DataW-1:0] rdata;
    logic             err;

    modport master (
        output req, we, addr, wdata, err,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata, err,
        output ack, rdata
    );

endinterface

// File: rtl/dmem_ctrl.sv
// Turns a single-cycle mem-stage access into a req/ack bus transaction, stalling the
// pipeline until ack (or a bounded timeout) and returning load data in DONE.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TimeoutDefault
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_ce_i,
    input  logic [WeW-1:0]   mem_we_i,
    input  logic [AddrW-1:0] mem_addr_i,
    input  logic [DataW-1:0] mem_data_i,
    output logic [DataW-1:0] mem_rdata_o,
    output logic             mem_stall_o,
    dmem_ctrl_if.master      bus
);

    localparam logic [TimerW-1:0] TimeoutCnt = TimerW'(TIMEOUT);

    state_e             r_state, w_state_d;
    logic               r_req, w_req_d;
    logic [WeW-1:0]     r_we, w_we_d;
    logic [AddrW-1:0]   r_addr, w_addr_d;
    logic [DataW-1:0]   r_wdata, w_wdata_d;
    logic [DataW-1:0]   r_rdata, w_rdata_d;
    logic               r_err, w_err_d;
    logic [TimerW-1:0]  r_timer, w_timer_d;

    always_comb begin
        w_state_d = r_state;
        w_req_d   = r_req;
        w_we_d    = r_we;
        w_addr_d  = r_addr;
        w_wdata_d = r_wdata;
        w_rdata_d = r_rdata;
        w_err_d   = 1'b0;
        w_timer_d = r_timer;

        unique case (r_state)
            StIdle: begin
                if (mem_ce_i) begin
                    w_we_d    = mem_we_i;
                    w_addr_d  = mem_addr_i;
                    w_wdata_d = mem_data_i;
                    w_req_d   = 1'b1;
                    w_timer_d = '0;
                    w_state_d = StBusy;
                end
            end
            StBusy: begin
                // Ack takes priority over a timeout expiring in the same cycle.
                if (bus.ack) begin
                    w_req_d   = 1'b0;
                    w_rdata_d = (r_we == '0) ? bus.rdata : '0;
                    w_state_d = StDone;
                end else if ((TIMEOUT != 0) && (r_timer == TimeoutCnt)) begin
                    w_req_d   = 1'b0;
                    w_rdata_d = '0;
                    w_err_d   = 1'b1;
                    w_state_d = StDone;
                end else begin
                    w_timer_d = r_timer + 1'b1;
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_req   <= 1'b0;
            r_we    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_d;
            r_req   <= w_req_d;
            r_we    <= w_we_d;
            r_addr  <= w_addr_d;
            r_wdata <= w_wdata_d;
            r_rdata <= w_rdata_d;
            r_err   <= w_err_d;
            r_timer <= w_timer_d;
        end
    end

    // Stall through the request cycle and all of BUSY; DONE releases the pipeline.
    assign mem_stall_o = ((r_state == StIdle) && mem_ce_i) || (r_state == StBusy);
    assign mem_rdata_o = r_rdata;

    assign bus.req   = r_req;
    assign bus.we    = r_we;
    assign bus.addr  = r_addr;
    assign bus.wdata = r_wdata;
    assign bus.err   = r_err;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with TIMEOUT=4: loads, stores, timeout, reset, back-to-back.
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             mem_ce;
    logic [WeW-1:0]   mem_we;
    logic [AddrW-1:0] mem_addr;
    logic [DataW-1:0] mem_data;
    logic [DataW-1:0] mem_rdata;
    logic             mem_stall;

    int n_cmp;
    int n_err;

    dmem_ctrl_if bus_if ();

    dmem_ctrl #(
        .TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_ce_i    (mem_ce),
        .mem_we_i    (mem_we),
        .mem_addr_i  (mem_addr),
        .mem_data_i  (mem_data),
        .mem_rdata_o (mem_rdata),
        .mem_stall_o (mem_stall),
        .bus         (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 2ns after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        mem_ce       = 1'b0;
        mem_we       = '0;
        mem_addr     = '0;
        mem_data     = '0;
        bus_if.ack   = 1'b0;
        bus_if.rdata = '0;

        #3;
        check("rst_req", bus_if.req, 0);
        check("rst_we", bus_if.we, 0);
        check("rst_addr", bus_if.addr, 0);
        check("rst_wdata", bus_if.wdata, 0);
        check("rst_rdata", mem_rdata, 0);
        check("rst_err", bus_if.err, 0);
        check("rst_stall", mem_stall, 0);
        #2 rst_n = 1'b1;
        tick();

        // Load, zero-wait ack
        mem_ce = 1'b1; mem_we = 4'b0000; mem_addr = 32'h100;
        #1;
        check("ld0_c0_stall", mem_stall, 1);
        check("ld0_c0_req", bus_if.req, 0);
        tick();
        mem_ce = 1'b0;
        bus_if.ack = 1'b1; bus_if.rdata = 32'hCAFEBABE;
        #1;
        check("ld0_c1_req", bus_if.req, 1);
        check("ld0_c1_addr", bus_if.addr, 32'h100);
        check("ld0_c1_we", bus_if.we, 0);
        check("ld0_c1_stall", mem_stall, 1);
        tick();
        bus_if.ack = 1'b0;
        #1;
        check("ld0_done_stall", mem_stall, 0);
        check("ld0_done_rdata", mem_rdata, 32'hCAFEBABE);
        check("ld0_done_req", bus_if.req, 0);
        check("ld0_done_err", bus_if.err, 0);
        tick();
        check("ld0_idle_stall", mem_stall, 0);
        check("ld0_idle_hold", mem_rdata, 32'hCAFEBABE);

        // Timeout: no ack for the whole of BUSY (timer 0..4)
        mem_ce = 1'b1; mem_we = 4'b0000; mem_addr = 32'h000DEAD0;
        #1;
        tick();
        mem_ce = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("to_busy%0d_stall", i), mem_stall, 1);
            check($sformatf("to_busy%0d_err", i), bus_if.err, 0);
            check($sformatf("to_busy%0d_req", i), bus_if.req, 1);
            tick();
        end
        #1;
        check("to_done_err", bus_if.err, 1);
        check("to_done_rdata", mem_rdata, 0);
        check("to_done_stall", mem_stall, 0);
        check("to_done_req", bus_if.req, 0);
        tick();
        check("to_idle_err", bus_if.err, 0);
        tick();
        bus_if.ack = 1'b1; bus_if.rdata = 32'hFFFFFFFF;
        #1;
        check("spur_stall", mem_stall, 0);
        tick();
        bus_if.ack = 1'b0;
        #1;
        check("spur_rdata", mem_rdata, 0);
        check("spur_req", bus_if.req, 0);
        check("spur_err", bus_if.err, 0);
        check("spur_stall2", mem_stall, 0);
        tick();

        // Load with ack in the same cycle the timer reaches TIMEOUT
        mem_ce = 1'b1; mem_we = 4'b0000; mem_addr = 32'h300;
        #1;
        tick();
        mem_ce = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                bus_if.ack = 1'b1; bus_if.rdata = 32'h12345678;
            end
            #1;
            check($sformatf("race_busy%0d_stall", i), mem_stall, 1);
            tick();
        end
        bus_if.ack = 1'b0;
        #1;
        check("race_done_rdata", mem_rdata, 32'h12345678);
        check("race_done_err", bus_if.err, 0);
        check("race_done_stall", mem_stall, 0);
        tick();

        // Store, 5-cycle wait; ack on the last permitted BUSY cycle
        mem_ce = 1'b1; mem_we = 4'b0011; mem_addr = 32'h204; mem_data = 32'h0000BEEF;
        #1;
        check("st_c0_stall", mem_stall, 1);
        tick();
        mem_ce = 1'b0; mem_we = 4'b1111; mem_addr = 32'hFFFF; mem_data = 32'h1;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                bus_if.ack = 1'b1; bus_if.rdata = 32'hAAAAAAAA;
            end
            #1;
            check($sformatf("st_busy%0d_we", i), bus_if.we, 4'b0011);
            check($sformatf("st_busy%0d_addr", i), bus_if.addr, 32'h204);
            check($sformatf("st_busy%0d_wdata", i), bus_if.wdata, 32'h0000BEEF);
            check($sformatf("st_busy%0d_stall", i), mem_stall, 1);
            tick();
        end
        bus_if.ack = 1'b0;
        #1;
        check("st_done_stall", mem_stall, 0);
        check("st_done_rdata", mem_rdata, 0);
        check("st_done_err", bus_if.err, 0);
        check("st_done_req", bus_if.req, 0);
        tick();

        // Back-to-back loads with ce held high
        mem_ce = 1'b1; mem_we = 4'b0000; mem_addr = 32'h10;
        #1;
        tick();
        bus_if.ack = 1'b1; bus_if.rdata = 32'h000000A0;
        #1;
        check("b2b_a_req", bus_if.req, 1);
        check("b2b_a_addr", bus_if.addr, 32'h10);
        tick();
        bus_if.ack = 1'b0; mem_addr = 32'h14;
        #1;
        check("b2b_a_done_rdata", mem_rdata, 32'h000000A0);
        check("b2b_a_done_stall", mem_stall, 0);
        tick();
        #1;
        check("b2b_idle_req", bus_if.req, 0);
        check("b2b_idle_stall", mem_stall, 1);
        tick();
        bus_if.ack = 1'b1; bus_if.rdata = 32'h000000B4;
        #1;
        check("b2b_b_req", bus_if.req, 1);
        check("b2b_b_addr", bus_if.addr, 32'h14);
        tick();
        bus_if.ack = 1'b0; mem_ce = 1'b0;
        #1;
        check("b2b_b_done_rdata", mem_rdata, 32'h000000B4);
        tick();

        // Asynchronous reset in the middle of BUSY
        mem_ce = 1'b1; mem_we = 4'b0000; mem_addr = 32'h400;
        #1;
        tick();
        mem_ce = 1'b0;
        #1;
        check("arst_pre_req", bus_if.req, 1);
        rst_n = 1'b0;
        #1;
        check("arst_req", bus_if.req, 0);
        check("arst_stall", mem_stall, 0);
        check("arst_addr", bus_if.addr, 0);
        check("arst_rdata", mem_rdata, 0);
        #1 rst_n = 1'b1;
        tick();
        mem_ce = 1'b1; mem_addr = 32'h500;
        #1;
        check("post_c0_stall", mem_stall, 1);
        tick();
        mem_ce = 1'b0;
        bus_if.ack = 1'b1; bus_if.rdata = 32'h55AA55AA;
        #1;
        check("post_c1_addr", bus_if.addr, 32'h500);
        tick();
        bus_if.ack = 1'b0;
        #1;
        check("post_done_rdata", mem_rdata, 32'h55AA55AA);
        check("post_done_stall", mem_stall, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory access controller between the combinational `mem` stage and the data SRAM bus. It turns the stage's single-cycle access request (`ce`/`we`/`addr`/`data`) into a req/ack bus transaction of arbitrary latency. It holds the pipeline through `mem_stall_o` until the access completes, then returns load data to `mem`. A bounded timeout aborts accesses to dead addresses.

## Interface
- `TIMEOUT`, 255: max cycles in BUSY waiting for ack; 0 disables timeout.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `mem_ce_i`  in  1  access request from `mem` (`mem_ce_o`).
- `mem_we_i`  in  4  byte write enables; 0000 = load.
- `mem_addr_i`  in  32  access address.
- `mem_data_i`  in  32  store data, byte-lane aligned.
- `mem_rdata_o`  out  32  load data to `mem`; valid in DONE.
- `mem_stall_o`  out  1  stall request into the `mem` stage's `stallreq` path.
- `bus_req_o`  out  1  bus request, registered.
- `bus_we_o`  out  4  registered copy of `mem_we_i`.
- `bus_addr_o`  out  32  registered copy of `mem_addr_i`.
- `bus_wdata_o`  out  32  registered copy of `mem_data_i`.
- `bus_ack_i`  in  1  single-cycle completion strobe from SRAM side.
- `bus_rdata_i`  in  32  read data, valid with `bus_ack_i` on loads.
- `bus_err_o`  out  1  one-cycle pulse on timeout abort.

## Operation
- States: IDLE, BUSY, DONE (encodings in `defines.v`).
- IDLE:
  - `mem_ce_i`=0: stay, no stall.
  - `mem_ce_i`=1: latch `we`/`addr`/`data` into `bus_*_o`, set `bus_req_o`, clear the timer, go to BUSY.
  - `mem_stall_o` is combinationally 1 in this cycle.
- BUSY:
  - `mem_stall_o`=1 and `bus_req_o`=1. `bus_*_o` are held constant.
  - On `bus_ack_i`: drop `bus_req_o`. If the access is a load, capture `bus_rdata_i` into the read register; if a store, clear the read register. Go to DONE.
  - Otherwise the timer increments. When the timer reaches `TIMEOUT` (nonzero), drop the request, clear the read register, pulse `bus_err_o`, and go to DONE.
- DONE:
  - `mem_stall_o`=0 so the pipeline advances at this edge.
  - `mem_rdata_o` = read register.
  - Unconditional transition to IDLE.
- `mem_rdata_o` holds its value outside DONE. `mem` samples it only in DONE.
- `bus_ack_i` outside BUSY is ignored (covers a late ack after timeout).
- `mem_ce_i` changes during BUSY are ignored; the latched request is authoritative.
- Timer is 8 bits; `TIMEOUT` ≤ 255.

## Timing
- Reset values: state IDLE, `bus_req_o`=0, `bus_we_o`=0, `bus_addr_o`=0, `bus_wdata_o`=0, `mem_rdata_o`=0, `bus_err_o`=0, timer 0.
- `mem_stall_o` is 0 in reset, because it is derived from IDLE && `mem_ce_i`=0.
- Reset mid-access: `bus_req_o` falls asynchronously and the in-flight transaction is abandoned. The SRAM side must tolerate this.
- Cycle numbering:
  - Cycle 0: IDLE with `ce`.
  - Cycle 1: `bus_req_o` is first visible.
  - Ack sampled in cycle k ≥ 1.
  - Cycle k+1: DONE.
  - Minimum access is 3 cycles (zero-wait ack at cycle 1); stall is high for k+1 cycles.
- Back-to-back accesses: a new `mem_ce_i` is first seen in the IDLE cycle following DONE. There is no overlap, and at most one request is outstanding.
- Ack and timeout in the same cycle: ack wins, `bus_err_o` stays 0, data is captured.
- `TIMEOUT`=0: BUSY waits indefinitely.

## Structure
- State encodings, `TIMEOUT` default and bus-width macros go in `defines.v`, next to `RegBus`.
- Single module; the timer is inline. No sub-module is warranted.
- `mem_stall_o` is ORed into the existing `mem` stage stall path at the top level.

## Test plan
- Load, zero-wait: `ce`=1, `we`=0000, `addr`=0x100. Ack at cycle 1 with 0xCAFEBABE → `mem_rdata_o`=0xCAFEBABE in cycle 2 (DONE); stall=1 in cycles 0–1 and 0 in cycle 2.
- Store, 5-cycle wait: `we`=0011, `addr`=0x204, `data`=0x0000BEEF → `bus_*` stable for 5 cycles, stall released the cycle after ack, `mem_rdata_o`=0.
- Timeout: `TIMEOUT`=4, no ack → `bus_err_o` pulses once at the DONE entry edge, `mem_rdata_o`=0. A spurious ack 2 cycles later causes no state change.
- Ack coinciding with timer=`TIMEOUT` → data captured, `bus_err_o`=0.
- Async reset asserted mid-BUSY → `bus_req_o` and `mem_stall_o` drop without a clock edge; after release, a new load completes normally.
- Back-to-back loads from 0x10 and 0x14 → two distinct requests, exactly one IDLE cycle between the DONE of the first and the req of the second.
